// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, ALU op and memory handshake from the current state.
module multicycle_ctrl #(
  parameter logic [2:0] AND = 3'b000,
  parameter logic [2:0] OR  = 3'b001,
  parameter logic [2:0] ADD = 3'b010,
  parameter logic [2:0] SUB = 3'b110,
  parameter logic [2:0] SLT = 3'b111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic [2:0] ALU,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic       RegWrite,
  output logic [1:0] RegDest,
  output logic [1:0] MemtoReg,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2, MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTYPE  = 4'd6, RWB   = 4'd7,
    BRANCH = 4'd8,  ITYPE  = 4'd9,  IWB    = 4'd10, JUMP = 4'd11
  } state_t;

  state_t cur, nxt;

  logic       is_lw, is_sw, is_mem, is_rtype, is_jr, is_beq, is_bne, is_itype, is_j, is_jal, is_nop;
  logic [2:0] r_alu, i_alu;

  always_comb begin
    is_lw    = (op == 6'b100011);
    is_sw    = (op == 6'b101011);
    is_mem   = is_lw | is_sw;
    is_jr    = (op == 6'b000000) && (func == 6'b001000);
    is_nop   = (op == 6'b000000) && (func == 6'b000000);
    is_beq   = (op == 6'b000100);
    is_bne   = (op == 6'b000101);
    is_j     = (op == 6'b000010);
    is_jal   = (op == 6'b000011);
    is_itype = (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001010) || (op == 6'b001000);
    is_rtype = 1'b0;
    r_alu    = ADD;
    case (func)
      6'b100000, 6'b100001: begin r_alu = ADD; is_rtype = (op == 6'b000000); end
      6'b100010, 6'b100011: begin r_alu = SUB; is_rtype = (op == 6'b000000); end
      6'b100100:            begin r_alu = AND; is_rtype = (op == 6'b000000); end
      6'b100101:            begin r_alu = OR;  is_rtype = (op == 6'b000000); end
      6'b101010:            begin r_alu = SLT; is_rtype = (op == 6'b000000); end
      default:              ;
    endcase
    case (op)
      6'b001100: i_alu = AND;
      6'b001101: i_alu = OR;
      6'b001010: i_alu = SLT;
      default:   i_alu = ADD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (is_mem)                nxt = MEMADR;
        else if (is_rtype)         nxt = RTYPE;
        else if (is_jr)            nxt = JUMP;
        else if (is_beq || is_bne) nxt = BRANCH;
        else if (is_itype)         nxt = ITYPE;
        else if (is_j || is_jal)   nxt = JUMP;
        else                       nxt = FETCH;
      end
      MEMADR: nxt = is_lw ? MEMRD : MEMWR;
      MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
      RTYPE:  nxt = RWB;
      ITYPE:  nxt = IWB;
      default: nxt = FETCH;
    endcase
  end

  // Outputs are gated by rst_n so everything reads zero while reset is held.
  always_comb begin
    mem_req = 1'b0; mem_we = 1'b0; IorD = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0;
    PCSource = '0; ALU = '0; ALUsrcA = 1'b0; ALUsrcB = '0; RegWrite = 1'b0;
    RegDest = '0; MemtoReg = '0; instr_done = 1'b0; illegal = 1'b0;
    state = cur;
    if (rst_n) begin
      case (cur)
        FETCH: begin
          mem_req = 1'b1; ALUsrcB = 2'b01; ALU = ADD;
          IRWrite = mem_ready; PCWrite = mem_ready;
        end
        DECODE: begin
          ALUsrcB = 2'b11; ALU = ADD;
          instr_done = is_nop;
          illegal = !(is_mem || is_rtype || is_jr || is_beq || is_bne || is_itype
                      || is_j || is_jal || is_nop);
        end
        MEMADR: begin ALUsrcA = 1'b1; ALUsrcB = 2'b10; ALU = ADD; end
        MEMRD:  begin mem_req = 1'b1; IorD = 1'b1; end
        MEMWB:  begin RegWrite = 1'b1; MemtoReg = 2'b01; instr_done = 1'b1; end
        MEMWR:  begin mem_req = 1'b1; mem_we = 1'b1; IorD = 1'b1; instr_done = mem_ready; end
        RTYPE:  begin ALUsrcA = 1'b1; ALU = r_alu; end
        RWB:    begin RegWrite = 1'b1; RegDest = 2'b01; ALU = r_alu; instr_done = 1'b1; end
        BRANCH: begin
          ALUsrcA = 1'b1; ALU = SUB; PCSource = 2'b01; instr_done = 1'b1;
          PCWrite = is_beq ? zero : !zero;
        end
        ITYPE:  begin ALUsrcA = 1'b1; ALUsrcB = 2'b10; ALU = i_alu; end
        IWB:    begin RegWrite = 1'b1; ALU = i_alu; instr_done = 1'b1; end
        JUMP: begin
          PCWrite = 1'b1; instr_done = 1'b1;
          PCSource = is_jr ? 2'b11 : 2'b10;
          if (is_jal) begin RegWrite = 1'b1; RegDest = 2'b10; MemtoReg = 2'b10; end
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into a per-cycle script of
// expected outputs from its class and chosen wait states, then replayed against the DUT.
module tb_multicycle_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_we, IorD, IRWrite, PCWrite, ALUsrcA, RegWrite, instr_done, illegal;
  logic [1:0] PCSource, ALUsrcB, RegDest, MemtoReg;
  logic [2:0] ALU;
  logic [3:0] state;

  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_SUB = 3'b110, A_SLT = 3'b111;

  multicycle_ctrl #(.AND(A_AND), .OR(A_OR), .ADD(A_ADD), .SUB(A_SUB), .SLT(A_SLT)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSource(PCSource), .ALU(ALU), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .RegWrite(RegWrite),
    .RegDest(RegDest), .MemtoReg(MemtoReg), .instr_done(instr_done), .illegal(illegal),
    .state(state));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, IorD, IRWrite, PCWrite;
    logic [1:0] PCSource;
    logic [2:0] ALU;
    logic       ALUsrcA;
    logic [1:0] ALUsrcB;
    logic       RegWrite;
    logic [1:0] RegDest, MemtoReg;
    logic       instr_done, illegal;
    logic [3:0] state;
  } outs_t;

  typedef struct { outs_t exp; logic mr; } step_t;
  typedef enum int { K_R, K_JR, K_NOP, K_LW, K_SW, K_BEQ, K_BNE, K_I, K_J, K_JAL, K_ILL } kind_t;

  outs_t obs;
  always_comb obs = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSource, ALU, ALUsrcA, ALUsrcB,
                     RegWrite, RegDest, MemtoReg, instr_done, illegal, state};

  int    checks = 0, errors = 0;
  step_t q[$];
  string cur_name;

  localparam int NI = 21;
  logic [5:0] t_op[NI], t_fn[NI];
  kind_t      t_kind[NI];
  logic [2:0] t_alu[NI];
  string      t_name[NI];

  task automatic chk(input outs_t got, input outs_t want, input string tag);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic put(input int i, input logic [5:0] o, input logic [5:0] f, input kind_t k,
                     input logic [2:0] a, input string n);
    t_op[i] = o; t_fn[i] = f; t_kind[i] = k; t_alu[i] = a; t_name[i] = n;
  endtask

  function automatic outs_t fetch_exp(input logic ready);
    outs_t o = '0;
    o.mem_req = 1'b1; o.ALUsrcB = 2'b01; o.ALU = A_ADD;
    o.IRWrite = ready; o.PCWrite = ready;
    return o;
  endfunction

  task automatic push(input outs_t o, input logic mr);
    step_t s;
    s.exp = o; s.mr = mr;
    q.push_back(s);
  endtask

  // Expand one instruction into its expected cycle-by-cycle script.
  task automatic build(input int idx, input logic z, input int w0, input int w1);
    outs_t o;
    kind_t k = t_kind[idx];
    q.delete();
    op = t_op[idx]; func = t_fn[idx]; zero = z; cur_name = t_name[idx];
    for (int i = 0; i <= w0; i++) push(fetch_exp(i == w0), i == w0);
    o = '0; o.state = 4'd1; o.ALUsrcB = 2'b11; o.ALU = A_ADD;
    o.instr_done = (k == K_NOP); o.illegal = (k == K_ILL);
    push(o, 1'($urandom));
    if (k == K_LW || k == K_SW) begin
      o = '0; o.state = 4'd2; o.ALUsrcA = 1'b1; o.ALUsrcB = 2'b10; o.ALU = A_ADD;
      push(o, 1'($urandom));
      for (int i = 0; i <= w1; i++) begin
        o = '0; o.mem_req = 1'b1; o.IorD = 1'b1;
        o.state = (k == K_LW) ? 4'd3 : 4'd5;
        o.mem_we = (k == K_SW);
        o.instr_done = (k == K_SW) && (i == w1);
        push(o, i == w1);
      end
      if (k == K_LW) begin
        o = '0; o.state = 4'd4; o.RegWrite = 1'b1; o.MemtoReg = 2'b01; o.instr_done = 1'b1;
        push(o, 1'($urandom));
      end
    end else if (k == K_R || k == K_I) begin
      o = '0; o.state = (k == K_R) ? 4'd6 : 4'd9; o.ALUsrcA = 1'b1; o.ALU = t_alu[idx];
      o.ALUsrcB = (k == K_R) ? 2'b00 : 2'b10;
      push(o, 1'($urandom));
      o = '0; o.state = (k == K_R) ? 4'd7 : 4'd10; o.RegWrite = 1'b1; o.ALU = t_alu[idx];
      o.RegDest = (k == K_R) ? 2'b01 : 2'b00; o.instr_done = 1'b1;
      push(o, 1'($urandom));
    end else if (k == K_BEQ || k == K_BNE) begin
      o = '0; o.state = 4'd8; o.ALUsrcA = 1'b1; o.ALU = A_SUB; o.PCSource = 2'b01;
      o.PCWrite = (k == K_BEQ) ? z : !z; o.instr_done = 1'b1;
      push(o, 1'($urandom));
    end else if (k == K_J || k == K_JAL || k == K_JR) begin
      o = '0; o.state = 4'd11; o.PCWrite = 1'b1; o.instr_done = 1'b1;
      o.PCSource = (k == K_JR) ? 2'b11 : 2'b10;
      if (k == K_JAL) begin o.RegWrite = 1'b1; o.RegDest = 2'b10; o.MemtoReg = 2'b10; end
      push(o, 1'($urandom));
    end
  endtask

  task automatic run_steps(input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      mem_ready = s.mr;
      @(negedge clk);
      chk(obs, s.exp, cur_name);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input int idx, input logic z, input int w0, input int w1);
    build(idx, z, w0, w1);
    run_steps(1000);
  endtask

  initial begin
    put(0,  6'b000000, 6'b100000, K_R,   A_ADD, "add");
    put(1,  6'b000000, 6'b100001, K_R,   A_ADD, "addu");
    put(2,  6'b000000, 6'b100010, K_R,   A_SUB, "sub");
    put(3,  6'b000000, 6'b100011, K_R,   A_SUB, "subu");
    put(4,  6'b000000, 6'b100100, K_R,   A_AND, "and");
    put(5,  6'b000000, 6'b100101, K_R,   A_OR,  "or");
    put(6,  6'b000000, 6'b101010, K_R,   A_SLT, "slt");
    put(7,  6'b000000, 6'b001000, K_JR,  3'b0,  "jr");
    put(8,  6'b000000, 6'b000000, K_NOP, 3'b0,  "nop");
    put(9,  6'b100011, 6'b010101, K_LW,  3'b0,  "lw");
    put(10, 6'b101011, 6'b110011, K_SW,  3'b0,  "sw");
    put(11, 6'b000100, 6'b100000, K_BEQ, 3'b0,  "beq");
    put(12, 6'b000101, 6'b000111, K_BNE, 3'b0,  "bne");
    put(13, 6'b001100, 6'b101010, K_I,   A_AND, "andi");
    put(14, 6'b001101, 6'b000001, K_I,   A_OR,  "ori");
    put(15, 6'b001010, 6'b100010, K_I,   A_SLT, "slti");
    put(16, 6'b001000, 6'b111111, K_I,   A_ADD, "addi");
    put(17, 6'b000010, 6'b100100, K_J,   3'b0,  "j");
    put(18, 6'b000011, 6'b000000, K_JAL, 3'b0,  "jal");
    put(19, 6'b111111, 6'b100000, K_ILL, 3'b0,  "ill_op");
    put(20, 6'b000000, 6'b000001, K_ILL, 3'b0,  "ill_func");

    #1 chk(obs, '0, "reset_low");
    repeat (2) @(posedge clk);
    #1 chk(obs, '0, "reset_held");
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1 chk(obs, fetch_exp(1'b0), "fetch_after_reset");

    do_instr(0, 1'b0, 0, 0);
    do_instr(9, 1'b0, 0, 2);
    do_instr(11, 1'b1, 0, 0);
    do_instr(11, 1'b0, 0, 0);
    do_instr(12, 1'b1, 0, 0);
    do_instr(12, 1'b0, 0, 0);
    do_instr(19, 1'b0, 0, 0);
    do_instr(8, 1'b0, 0, 0);
    do_instr(18, 1'b0, 0, 0);
    do_instr(7, 1'b0, 0, 0);
    do_instr(10, 1'b0, 1, 1);
    do_instr(20, 1'b0, 2, 0);

    // Reset asserted mid-MEMWR, asynchronously to the clock.
    build(10, 1'b0, 0, 4);
    run_steps(4);
    mem_ready = 1'b0;
    #1 chk(obs, q[0].exp, "memwr_before_reset");
    rst_n = 1'b0;
    #1 chk(obs, '0, "reset_async_memwr");
    @(posedge clk);
    #1 chk(obs, '0, "reset_held_edge");
    rst_n = 1'b1;
    #1 chk(obs, fetch_exp(1'b0), "fetch_after_rerelease");
    q.delete();
    do_instr(0, 1'b0, 0, 0);

    for (int n = 0; n < 80; n++)
      do_instr(int'($urandom_range(0, NI - 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
